// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file and its pending-write scoreboard.
// The optional RF_DEBUG_PORT_EN build adds a debug read/busy port to regfile_wb_scoreboard.
package rf_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] regIdx_t;

    localparam regIdx_t ZERO_REG = 5'd0;

    // Largest number of outstanding writes a counter of the given width can track.
    function automatic int cntMax(input int cntW);
        return (1 << cntW) - 1;
    endfunction

endpackage

// File: rtl/rf_sb_entry.sv
// Pending-write counter for one architectural register: floored at zero, capped at max.
// With RF_DEBUG_PORT_EN defined it also exposes the raw (pre-writeback) busy flag.
module rf_sb_entry
    import rf_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec_wb,
    input  logic i_dec_kill,
    output logic o_busy_eff,
    output logic o_full
`ifdef RF_DEBUG_PORT_EN
    ,
    output logic o_busy_raw
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(cntMax(CNT_W));
    localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(cntMax(CNT_W));

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_up;
    logic [CNT_W:0]   w_dn;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_next;

    assign w_up   = {1'b0, r_cnt} + (CNT_W+1)'(i_inc);
    assign w_dn   = (CNT_W+1)'(i_dec_wb) + (CNT_W+1)'(i_dec_kill);
    assign w_diff = w_up - w_dn;

    // Decrements past zero are dropped; the cap only matters if the issue stall were bypassed.
    always_comb begin
        w_next = w_diff;
        if (w_up <= w_dn) begin
            w_next = '0;
        end else if (w_diff > MAX_EXT) begin
            w_next = MAX_EXT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next[CNT_W-1:0];
        end
    end

    // A writeback landing this cycle retires one pending write before decode looks at it.
    assign o_busy_eff = (r_cnt != '0) && !((r_cnt == CNT_W'(1)) && i_dec_wb);
    assign o_full     = (r_cnt == MAX_CNT) && !i_dec_wb;

`ifdef RF_DEBUG_PORT_EN
    assign o_busy_raw = (r_cnt != '0);
`endif

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// 32x32 register file with WB->read bypass and per-register pending-write scoreboard.
// Define RF_DEBUG_PORT_EN to add the dbg_addr/dbg_data/dbg_busy inspection port.
module regfile_wb_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 id_rd_we,
    input  logic [4:0]           id_rd,
    input  logic                 id_hold,
    input  logic                 kill_valid,
    input  logic [4:0]           kill_rd,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic [XLEN-1:0]      rd1,
    output logic [XLEN-1:0]      rd2,
    output logic                 raw_stall,
    output logic                 issue_fire
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [4:0]           dbg_addr,
    output logic [XLEN-1:0]      dbg_data,
    output logic                 dbg_busy
`endif
);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_full;
`ifdef RF_DEBUG_PORT_EN
    logic [NUM_REGS-1:0] w_busyRaw;
    assign w_busyRaw[0] = 1'b0;
`endif

    // x0 has no scoreboard entry, so it can never look busy or full.
    assign w_busy[0] = 1'b0;
    assign w_full[0] = 1'b0;

    generate
        for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
            rf_sb_entry #(
                .CNT_W(CNT_W)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .i_inc     (issue_fire && id_rd_we && (id_rd == REG_IDX_W'(g))),
                .i_dec_wb  (wb_en && (wb_addr == REG_IDX_W'(g))),
                .i_dec_kill(kill_valid && (kill_rd == REG_IDX_W'(g))),
                .o_busy_eff(w_busy[g]),
                .o_full    (w_full[g])
`ifdef RF_DEBUG_PORT_EN
                ,
                .o_busy_raw(w_busyRaw[g])
`endif
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != ZERO_REG)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1 = r_regs[id_rs1];
        if (id_rs1 == ZERO_REG) begin
            rd1 = '0;
        end else if (wb_en && (wb_addr == id_rs1)) begin
            rd1 = wb_data;
        end
        rd2 = r_regs[id_rs2];
        if (id_rs2 == ZERO_REG) begin
            rd2 = '0;
        end else if (wb_en && (wb_addr == id_rs2)) begin
            rd2 = wb_data;
        end
    end

    assign raw_stall  = id_valid && ((id_rs1_used && w_busy[id_rs1]) ||
                                     (id_rs2_used && w_busy[id_rs2]) ||
                                     (id_rd_we && w_full[id_rd]));
    assign issue_fire = id_valid && !raw_stall && !id_hold;

`ifdef RF_DEBUG_PORT_EN
    assign dbg_data = (dbg_addr == ZERO_REG) ? '0 : r_regs[dbg_addr];
    assign dbg_busy = w_busyRaw[dbg_addr];
`endif

endmodule
